// File: rtl/bscalc_fixed_pkg.sv
// Shared Q16.16 fixed-point definitions for the Black-Scholes calculator blocks:
// widths, ln-related constants, the truncating multiply and the ln FSM states.
package bscalc_fixed_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;

  localparam logic [WIDTH-1:0] ONE        = 32'h0001_0000;
  localparam logic [WIDTH-1:0] LN2        = 32'h0000_B172;
  localparam logic [WIDTH-1:0] INV3       = 32'h0000_5555;
  localparam logic [WIDTH-1:0] INV5       = 32'h0000_3333;
  localparam logic [WIDTH-1:0] INV7       = 32'h0000_2492;
  localparam logic [WIDTH-1:0] INV9       = 32'h0000_1C71;
  localparam logic [WIDTH-1:0] DOMAIN_ERR = 32'h8000_0000;

  // state      | meaning
  // ST_IDLE    | wait for a start rising edge, latch x
  // ST_NORM    | leading-one detect, x = m * 2^k, kick the divider
  // ST_DIV     | wait for z = (m-1)/(m+1)
  // ST_POW     | odd powers of z, one product per cycle
  // ST_TERMS   | atanh series sum
  // ST_COMBINE | 2*atanh(z) + k*ln2
  // ST_OUT     | publish y/err, raise done
  // ST_HOLD    | second done cycle
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_DIV,
    ST_POW,
    ST_TERMS,
    ST_COMBINE,
    ST_OUT,
    ST_HOLD
  } ln_state_e;

  // Signed Q16.16 multiply: full 64-bit product, keep bits [47:16] (truncating).
  function automatic logic [WIDTH-1:0] q_mul(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    return WIDTH'(p >>> FRAC);
  endfunction

endpackage

// File: rtl/natural_log_if.sv
// start/done handshake bundle for the natural-log unit.
interface natural_log_if;
  import bscalc_fixed_pkg::*;

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             done;
  logic             err;

  modport master (output start, output x, input y, input done, input err);
  modport slave  (input start, input x, output y, output done, output err);
endinterface

// File: rtl/natural_log_frac_divider.sv
// Restoring fractional divider: q = floor(num * 2^16 / den), valid for num < den.
// The first quotient bit is resolved on the start edge, so the 16th bit lands
// 15 edges later and valid pulses for one cycle afterwards.
module frac_divider
  import bscalc_fixed_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] num_i,
  input  logic [WIDTH-1:0] den_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] q_o
);

  localparam int ITER = FRAC;

  logic [WIDTH-1:0] rem_q, den_q, q_q;
  logic [4:0]       cnt_q;
  logic             busy_q, valid_q;

  logic [WIDTH-1:0] step_rem, step_den, rem_d;
  logic [WIDTH:0]   shifted;
  logic             bit_d;

  // One restoring step, fed from the operands on start, else from the running remainder.
  always_comb begin
    step_rem = start_i ? num_i : rem_q;
    step_den = start_i ? den_i : den_q;
    shifted  = {step_rem, 1'b0};
    bit_d    = (shifted >= {1'b0, step_den});
    rem_d    = bit_d ? WIDTH'(shifted - {1'b0, step_den}) : shifted[WIDTH-1:0];
  end

  // Iteration registers: load + first bit on start, then one bit per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q   <= '0;
      den_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_d;
        den_q  <= den_i;
        q_q    <= {{(WIDTH-1){1'b0}}, bit_d};
        cnt_q  <= 5'(ITER - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        q_q   <= {q_q[WIDTH-2:0], bit_d};
        cnt_q <= cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign q_o     = q_q;

endmodule

// File: rtl/natural_log.sv
// Sequential Q16.16 ln(x). x = m*2^k by leading-one detect, z = (m-1)/(m+1),
// ln(m) = 2*atanh(z) from the odd series. Latency 24 cycles for x > 0, the
// domain-error path (x <= 0) answers after one cycle with y = 0x80000000.
// Build option NATURAL_LOG_SERIES9_EN adds the z^9/9 term (latency 25).
module natural_log
  import bscalc_fixed_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  natural_log_if.slave  bus
);

`ifdef NATURAL_LOG_SERIES9_EN
  localparam logic [2:0] POW_LAST = 3'd4;
`else
  localparam logic [2:0] POW_LAST = 3'd3;
`endif

  ln_state_e        state_q;
  logic             prev_start_q;
  logic [WIDTH-1:0] x_q, z_q, z2_q, z3_q, z5_q, z7_q, t_q, result_q, y_q;
`ifdef NATURAL_LOG_SERIES9_EN
  logic [WIDTH-1:0] z9_q;
`endif
  logic [5:0]       k_q;
  logic [2:0]       pow_cnt_q;
  logic             err_next_q, err_q, done_q;

  logic             start_rise;
  logic [4:0]       lead_pos;
  logic [WIDTH-1:0] m_norm;
  logic [5:0]       k_norm;
  logic [WIDTH-1:0] k_ext, k_ln2;
  logic             div_start, div_busy, div_valid;
  logic [WIDTH-1:0] div_q;

  assign start_rise = bus.start & ~prev_start_q;
  assign div_start  = (state_q == ST_NORM);

  // Range reduction: leading one of the positive operand, mantissa into [1,2).
  always_comb begin
    lead_pos = 5'd0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (x_q[i]) lead_pos = 5'(i);
    end
    if (lead_pos >= 5'd16) m_norm = x_q >> (lead_pos - 5'd16);
    else                   m_norm = x_q << (5'd16 - lead_pos);
    k_norm = {1'b0, lead_pos} - 6'd16;
  end

  // k is an integer, so k*ln2 is already in Q16.16.
  always_comb begin
    k_ext = {{(WIDTH-6){k_q[5]}}, k_q};
    k_ln2 = k_ext * LN2;
  end

  frac_divider u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (div_start),
    .num_i   (m_norm - ONE),
    .den_i   (m_norm + ONE),
    .busy_o  (div_busy),
    .valid_o (div_valid),
    .q_o     (div_q)
  );

  // Sequencing FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prev_start_q <= 1'b0;
      x_q          <= '0;
      z_q          <= '0;
      z2_q         <= '0;
      z3_q         <= '0;
      z5_q         <= '0;
      z7_q         <= '0;
`ifdef NATURAL_LOG_SERIES9_EN
      z9_q         <= '0;
`endif
      t_q          <= '0;
      result_q     <= '0;
      y_q          <= '0;
      k_q          <= '0;
      pow_cnt_q    <= '0;
      err_next_q   <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      prev_start_q <= bus.start;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_rise) begin
            x_q <= bus.x;
            if ($signed(bus.x) <= 0) begin
              result_q   <= DOMAIN_ERR;
              err_next_q <= 1'b1;
              state_q    <= ST_OUT;
            end else begin
              err_next_q <= 1'b0;
              state_q    <= ST_NORM;
            end
          end
        end
        ST_NORM: begin
          k_q     <= k_norm;
          state_q <= ST_DIV;
        end
        ST_DIV: begin
          if (div_valid && !div_busy) begin
            z_q       <= div_q;
            pow_cnt_q <= 3'd0;
            state_q   <= ST_POW;
          end
        end
        ST_POW: begin
          case (pow_cnt_q)
            3'd0:    z2_q <= q_mul(z_q, z_q);
            3'd1:    z3_q <= q_mul(z2_q, z_q);
            3'd2:    z5_q <= q_mul(z3_q, z2_q);
            3'd3:    z7_q <= q_mul(z5_q, z2_q);
`ifdef NATURAL_LOG_SERIES9_EN
            3'd4:    z9_q <= q_mul(z7_q, z2_q);
`endif
            default: ;
          endcase
          pow_cnt_q <= pow_cnt_q + 3'd1;
          if (pow_cnt_q == POW_LAST) state_q <= ST_TERMS;
        end
        ST_TERMS: begin
`ifdef NATURAL_LOG_SERIES9_EN
          t_q <= z_q + q_mul(z3_q, INV3) + q_mul(z5_q, INV5) + q_mul(z7_q, INV7)
                     + q_mul(z9_q, INV9);
`else
          t_q <= z_q + q_mul(z3_q, INV3) + q_mul(z5_q, INV5) + q_mul(z7_q, INV7);
`endif
          state_q <= ST_COMBINE;
        end
        ST_COMBINE: begin
          result_q <= (t_q << 1) + k_ln2;
          state_q  <= ST_OUT;
        end
        ST_OUT: begin
          y_q     <= result_q;
          err_q   <= err_next_q;
          done_q  <= 1'b1;
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_natural_log.sv
// Directed bench for natural_log: hand-computed vectors, handshake timing,
// domain errors, ignored starts, held start, async reset abort.
module tb_natural_log;

`ifdef NATURAL_LOG_SERIES9_EN
  localparam int LAT = 25;
`else
  localparam int LAT = 24;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  natural_log_if bus ();

  natural_log dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    int          tol;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp, input int tol);
    longint diff;
    n_cmp++;
    diff = longint'($signed(got)) - longint'($signed(exp));
    if (diff < 0) diff = -diff;
    if (diff > longint'(tol)) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic launch(input logic [31:0] xin);
    bus.x     = xin;
    bus.start = 1'b1;
  endtask

  // Edges after E0 until done is seen (sampled on the falling edge); -1 on timeout.
  task automatic wait_done(input bit glitch, output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (glitch && k == 5) begin
        bus.x     = 32'h0;
        bus.start = 1'b1;
      end
      if (glitch && k == 6) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic done_width(output int len);
    len = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!bus.done) break;
      len++;
    end
  endtask

  task automatic count_done_rises(input int cycles, output int rises);
    logic prev;
    prev  = bus.done;
    rises = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done && !prev) rises++;
      prev = bus.done;
    end
  endtask

  initial begin
    int lat, len, rises;

    vecs[0] = '{32'h0001_0000, 32'h0000_0000, 0, 1'b0, LAT};
    vecs[1] = '{32'h0002_0000, 32'h0000_B172, 0, 1'b0, LAT};
    vecs[2] = '{32'h0000_8000, 32'hFFFF_4E8E, 0, 1'b0, LAT};
    vecs[3] = '{32'h0002_B7E1, 32'h0001_0000, 8, 1'b0, LAT};
    vecs[4] = '{32'h0000_0001, 32'hFFF4_E8E0, 8, 1'b0, LAT};
    vecs[5] = '{32'h7FFF_FFFF, 32'h000A_65AF, 8, 1'b0, LAT};
    vecs[6] = '{32'h0000_0000, 32'h8000_0000, 0, 1'b1, 1};
    vecs[7] = '{32'hFFFF_0000, 32'h8000_0000, 0, 1'b1, 1};
    vecs[8] = '{32'h0001_0000, 32'h0000_0000, 0, 1'b0, LAT};

    bus.start = 1'b0;
    bus.x     = '0;
    repeat (2) @(negedge clk);
    check_val("rst_y",    bus.y,    32'h0, 0);
    check_val("rst_done", 32'(bus.done), 32'h0, 0);
    check_val("rst_err",  32'(bus.err),  32'h0, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors, including both domain-error operands and the err clear.
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].x);
      wait_done(1'b0, lat);
      check_val($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat), 0);
      check_val($sformatf("v%0d_y", i),   bus.y,   vecs[i].y, vecs[i].tol);
      check_val($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].err), 0);
      done_width(len);
      check_val($sformatf("v%0d_dlen", i), 32'(len), 32'd2, 0);
    end

    // Back-to-back: new start in the IDLE cycle right after HOLD.
    launch(32'h0002_0000);
    wait_done(1'b0, lat);
    check_val("b2b_first_y", bus.y, 32'h0000_B172, 0);
    @(negedge clk);
    launch(32'h0000_8000);
    wait_done(1'b0, lat);
    check_val("b2b_lat", 32'(lat), 32'(LAT), 0);
    check_val("b2b_y",   bus.y, 32'hFFFF_4E8E, 0);
    done_width(len);
    check_val("b2b_dlen", 32'(len), 32'd2, 0);

    // A start edge with x=0 mid-computation must be ignored.
    launch(32'h0002_0000);
    wait_done(1'b1, lat);
    check_val("glitch_lat", 32'(lat), 32'(LAT), 0);
    check_val("glitch_y",   bus.y, 32'h0000_B172, 0);
    check_val("glitch_err", 32'(bus.err), 32'h0, 0);
    done_width(len);
    count_done_rises(40, rises);
    check_val("glitch_extra", 32'(rises), 32'd0, 0);

    // Start held high for 40 cycles gives exactly one result.
    launch(32'h0000_8000);
    count_done_rises(40, rises);
    bus.start = 1'b0;
    count_done_rises(10, len);
    check_val("hold_rises", 32'(rises + len), 32'd1, 0);
    check_val("hold_y",     bus.y, 32'hFFFF_4E8E, 0);

    // Async reset at E10 aborts and clears outputs immediately.
    launch(32'h0002_0000);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_val("abort_y",    bus.y, 32'h0, 0);
    check_val("abort_done", 32'(bus.done), 32'h0, 0);
    check_val("abort_err",  32'(bus.err),  32'h0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_done_rises(40, rises);
    check_val("abort_nodone", 32'(rises), 32'd0, 0);

    // Start already high on the first clock after reset release counts as an edge.
    @(negedge clk);
    reset_n = 1'b0;
    launch(32'h0002_0000);
    @(negedge clk);
    reset_n = 1'b1;
    wait_done(1'b0, lat);
    check_val("rel_lat", 32'(lat), 32'(LAT), 0);
    check_val("rel_y",   bus.y, 32'h0000_B172, 0);
    done_width(len);
    check_val("rel_dlen", 32'(len), 32'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
